// File: rtl/beta_dmem_pkg.sv
// -----------------------------------------------------------------------------
// beta_dmem_pkg
// Shared types and constants for the Beta data-memory responder.
//   - MMIO register offsets inside the 256-byte MMIO window
//   - wb_entry_t : one posted write (word index + data)
//   - addr_region_t : result of decoding a d_mem byte address
//   - decode_region() : maps a byte address onto a region
// -----------------------------------------------------------------------------
package beta_dmem_pkg;

   // Byte offsets of the MMIO registers relative to MMIO_BASE.
   localparam logic [7:0] CYCLE_OFS = 8'h00;  // free-running cycle counter, read-only
   localparam logic [7:0] HALT_OFS  = 8'h04;  // halt/result register, write-only

   typedef struct packed {
      logic [29:0] idx;   // word index, i.e. byte address [31:2]
      logic [31:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      REG_MEM,
      REG_MMIO,
      REG_UNMAPPED
   } addr_region_t;

   // The array occupies word indices [0, mem_words); the MMIO window starts at
   // mmio_base and runs to the top of the address space. Everything between
   // is unmapped.
   function automatic addr_region_t decode_region(input logic [31:0] addr,
                                                  input logic [31:0] mmio_base,
                                                  input int unsigned mem_words);
      addr_region_t region;
      if ({2'b00, addr[31:2]} < mem_words) begin
         region = REG_MEM;
      end else if (addr >= mmio_base) begin
         region = REG_MMIO;
      end else begin
         region = REG_UNMAPPED;
      end
      return region;
   endfunction

endpackage : beta_dmem_pkg

// File: rtl/beta_wbuf.sv
// -----------------------------------------------------------------------------
// beta_wbuf
// Circular FIFO of posted array writes with a parallel youngest-match lookup.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset (empties the FIFO)
//   push, push_entry  enqueue request; accepted when not full or when popping
//   pop               dequeue the head entry (ignored when empty)
//   head              oldest entry, valid when !empty
//   full, empty       occupancy flags
//   count             current occupancy, 0..DEPTH
//   lookup_idx        word index to search for
//   lookup_hit        some valid entry matches lookup_idx
//   lookup_data       data of the youngest matching entry
// -----------------------------------------------------------------------------
module beta_wbuf
   import beta_dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  wb_entry_t                  push_entry,
   input  logic                       pop,
   output wb_entry_t                  head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   input  logic [29:0]                lookup_idx,
   output logic                       lookup_hit,
   output logic [31:0]                lookup_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t        entries [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full buffer can still take a write in a cycle that frees a slot.
   assign do_push = push && (!full || do_pop);
   assign head    = entries[rd_ptr];

   // Pointers are PW bits wide, so DEPTH being a power of two makes the
   // increment wrap modulo DEPTH for free.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of statement order between blocks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: entry storage has no reset; validity comes entirely from the
   // pointers and count, and leaving storage unreset lets it map to plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) entries[wr_ptr] <= push_entry;
   end

   // Walk from oldest to youngest; a later match overwrites an earlier one, so
   // the youngest matching entry wins.
   // NOTE: every output of this always_comb gets a default before the loop so
   // no path leaves it unassigned, which would infer a latch.
   always_comb begin
      logic [PW-1:0] slot;
      lookup_hit  = 1'b0;
      lookup_data = '0;
      slot        = rd_ptr;
      for (int k = 0; k < int'(DEPTH); k++) begin
         slot = rd_ptr + PW'(k);
         if ((k < int'(count)) && (entries[slot].idx == lookup_idx)) begin
            lookup_hit  = 1'b1;
            lookup_data = entries[slot].data;
         end
      end
   end

endmodule : beta_wbuf

// File: rtl/beta_dmem.sv
// -----------------------------------------------------------------------------
// beta_dmem
// Data-memory responder for the Beta core's d_mem_* port: word-addressed
// array behind a posted write buffer with read forwarding, plus an MMIO
// window holding a free-running cycle counter and a halt/result register.
//
// Ports:
//   clk           core clock
//   rst           asynchronous reset, active-low
//   d_mem_w_addr  byte address shared by reads and writes; [1:0] ignored
//   d_mem_w_data  write data
//   d_mem_we      write strobe, sampled at posedge clk
//   d_mem_oe      read enable; also blocks buffer drain in that cycle
//   d_mem_r_data  combinational read data (0 while in reset or oe=0)
//   halt_valid    set by the first write to HALT, held until reset
//   halt_code     data of the first HALT write
//   err_range     sticky: access to an unmapped address
//   err_overflow  sticky: array write dropped because the buffer was full
//   wb_count      current write-buffer occupancy
// -----------------------------------------------------------------------------
module beta_dmem
   import beta_dmem_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned WB_DEPTH  = 4,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   d_mem_w_addr,
   input  logic [31:0]                   d_mem_w_data,
   input  logic                          d_mem_we,
   input  logic                          d_mem_oe,
   output logic [31:0]                   d_mem_r_data,
   output logic                          halt_valid,
   output logic [31:0]                   halt_code,
   output logic                          err_range,
   output logic                          err_overflow,
   output logic [$clog2(WB_DEPTH):0]     wb_count
);

   localparam int AW = $clog2(MEM_WORDS);

   // ---------------------------------------------------------------- decode
   addr_region_t   region;
   logic [29:0]    idx;
   logic [AW-1:0]  mem_addr;
   logic [29:0]    mmio_widx;
   logic           cycle_sel;
   logic           halt_sel;

   assign region    = decode_region(d_mem_w_addr, MMIO_BASE, MEM_WORDS);
   assign idx       = d_mem_w_addr[31:2];
   assign mem_addr  = idx[AW-1:0];
   // Word offset into the MMIO window; byte lanes are ignored.
   assign mmio_widx = idx - MMIO_BASE[31:2];
   assign cycle_sel = (region == REG_MMIO) && (mmio_widx == 30'(CYCLE_OFS[7:2]));
   assign halt_sel  = (region == REG_MMIO) && (mmio_widx == 30'(HALT_OFS[7:2]));

   // ---------------------------------------------------------- write buffer
   wb_entry_t  push_entry;
   wb_entry_t  head;
   logic       mem_we;
   logic       drain;
   logic       wb_full;
   logic       wb_empty;
   logic       fwd_hit;
   logic [31:0] fwd_data;

   assign mem_we     = d_mem_we && (region == REG_MEM);
   // Any read cycle owns the array port, so the buffer only drains when idle.
   assign drain      = !d_mem_oe && !wb_empty;
   assign push_entry = '{idx: idx, data: d_mem_w_data};

   beta_wbuf #(
      .DEPTH (WB_DEPTH)
   ) u_wbuf (
      .clk         (clk),
      .rst         (rst),
      .push        (mem_we),
      .push_entry  (push_entry),
      .pop         (drain),
      .head        (head),
      .full        (wb_full),
      .empty       (wb_empty),
      .count       (wb_count),
      .lookup_idx  (idx),
      .lookup_hit  (fwd_hit),
      .lookup_data (fwd_data)
   );

   // ----------------------------------------------------------------- array
   // Array contents survive reset; only the buffer in front of it is flushed.
   logic [31:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (drain) mem[head.idx[AW-1:0]] <= head.data;
   end

   // ------------------------------------------------------------------ MMIO
   logic [31:0] cycle_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
      end
   end

   // Only the first HALT write is captured; the code then holds until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halt_valid <= 1'b0;
         halt_code  <= '0;
      end else if (d_mem_we && halt_sel && !halt_valid) begin
         halt_valid <= 1'b1;
         halt_code  <= d_mem_w_data;
      end
   end

   // ----------------------------------------------------------- error flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_range    <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         if ((d_mem_we || d_mem_oe) && (region == REG_UNMAPPED)) err_range <= 1'b1;
         // Matches the buffer's own acceptance rule: full and nothing leaving.
         if (mem_we && wb_full && !drain) err_overflow <= 1'b1;
      end
   end

   // ------------------------------------------------------------- read path
   // Forwarding sees the buffer before this cycle's enqueue, so a same-cycle
   // write to the read address returns the pre-write value.
   always_comb begin
      d_mem_r_data = '0;
      if (rst && d_mem_oe) begin
         unique case (region)
            REG_MEM:  d_mem_r_data = fwd_hit ? fwd_data : mem[mem_addr];
            REG_MMIO: if (cycle_sel) d_mem_r_data = cycle_q;
            default:  d_mem_r_data = '0;
         endcase
      end
   end

   // Index bits above the array size only matter to the decoder.
   logic unused_idx_bits;
   assign unused_idx_bits = ^{head.idx[29:AW], d_mem_w_addr[1:0]};

endmodule : beta_dmem

// File: tb/tb_beta_dmem.sv
// -----------------------------------------------------------------------------
// tb_beta_dmem
// Directed bench for beta_dmem. The stimulus thread applies inputs just after
// each rising edge and queues the values the outputs must show in that cycle;
// a monitor drains the queue on every falling edge and compares.
// -----------------------------------------------------------------------------
module tb_beta_dmem;

   localparam int unsigned MEM_WORDS = 1024;
   localparam int unsigned WB_DEPTH  = 4;
   localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;
   localparam logic [31:0] CYC_A     = MMIO_BASE;
   localparam logic [31:0] HALT_A    = MMIO_BASE + 32'd4;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [31:0]                 d_mem_w_addr;
   logic [31:0]                 d_mem_w_data;
   logic                        d_mem_we;
   logic                        d_mem_oe;
   logic [31:0]                 d_mem_r_data;
   logic                        halt_valid;
   logic [31:0]                 halt_code;
   logic                        err_range;
   logic                        err_overflow;
   logic [$clog2(WB_DEPTH):0]   wb_count;

   beta_dmem #(
      .MEM_WORDS (MEM_WORDS),
      .WB_DEPTH  (WB_DEPTH),
      .MMIO_BASE (MMIO_BASE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .d_mem_w_addr (d_mem_w_addr),
      .d_mem_w_data (d_mem_w_data),
      .d_mem_we     (d_mem_we),
      .d_mem_oe     (d_mem_oe),
      .d_mem_r_data (d_mem_r_data),
      .halt_valid   (halt_valid),
      .halt_code    (halt_code),
      .err_range    (err_range),
      .err_overflow (err_overflow),
      .wb_count     (wb_count)
   );

   always #5 clk = ~clk;

   typedef enum int {OBS_RDATA, OBS_COUNT, OBS_HVALID, OBS_HCODE, OBS_ERANGE, OBS_EOVF} obs_e;
   typedef struct {
      string       name;
      obs_e        obs;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] observe(input obs_e o);
      case (o)
         OBS_RDATA:  return d_mem_r_data;
         OBS_COUNT:  return 32'(wb_count);
         OBS_HVALID: return {31'd0, halt_valid};
         OBS_HCODE:  return halt_code;
         OBS_ERANGE: return {31'd0, err_range};
         default:    return {31'd0, err_overflow};
      endcase
   endfunction

   // Monitor: compare everything queued for the current cycle.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check(mon_e.name, observe(mon_e.obs), mon_e.exp);
      end
   end

   task automatic expect_v(input obs_e o, input logic [31:0] exp, input string name);
      exp_t e;
      e.name = name;
      e.obs  = o;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic we, input logic oe, input logic [31:0] addr,
                        input logic [31:0] data);
      d_mem_we     = we;
      d_mem_oe     = oe;
      d_mem_w_addr = addr;
      d_mem_w_data = data;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- reset state
      rst = 1'b0;
      drive(1'b0, 1'b1, CYC_A, 32'd0);
      cycle();
      expect_v(OBS_RDATA,  32'd0, "rst_rdata");
      expect_v(OBS_COUNT,  32'd0, "rst_count");
      expect_v(OBS_HVALID, 32'd0, "rst_hvalid");
      expect_v(OBS_HCODE,  32'd0, "rst_hcode");
      expect_v(OBS_ERANGE, 32'd0, "rst_erange");
      expect_v(OBS_EOVF,   32'd0, "rst_eovf");
      cycle();

      // ---------------- cycle counter: 10 edges after release reads 10
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      rst = 1'b1;
      repeat (10) cycle();
      drive(1'b0, 1'b1, CYC_A, 32'd0);
      expect_v(OBS_RDATA, 32'd10, "cycle_10");
      cycle();

      // wrap from all-ones to zero
      force dut.cycle_q = 32'hFFFF_FFFF;
      expect_v(OBS_RDATA, 32'hFFFF_FFFF, "cycle_forced");
      @(negedge clk);
      #1;
      release dut.cycle_q;
      cycle();
      expect_v(OBS_RDATA, 32'd0, "cycle_wrap");
      cycle();
      expect_v(OBS_RDATA, 32'd1, "cycle_after_wrap");
      cycle();

      // ---------------- three writes with drains in between
      drive(1'b1, 1'b0, 32'h0, 32'h11); expect_v(OBS_COUNT, 32'd0, "w0_count"); cycle();
      drive(1'b1, 1'b0, 32'h4, 32'h22); expect_v(OBS_COUNT, 32'd1, "w1_count"); cycle();
      drive(1'b1, 1'b0, 32'h8, 32'h33); expect_v(OBS_COUNT, 32'd1, "w2_count"); cycle();
      drive(1'b0, 1'b0, 32'h0, 32'h0);  expect_v(OBS_COUNT, 32'd1, "idle_count"); cycle();
      expect_v(OBS_COUNT, 32'd0, "drained_count"); cycle();
      drive(1'b0, 1'b1, 32'h0, 32'h0); expect_v(OBS_RDATA, 32'h11, "arr_w0"); cycle();
      drive(1'b0, 1'b1, 32'h4, 32'h0); expect_v(OBS_RDATA, 32'h22, "arr_w1"); cycle();
      drive(1'b0, 1'b1, 32'h8, 32'h0); expect_v(OBS_RDATA, 32'h33, "arr_w2"); cycle();

      // ---------------- forwarding, same-cycle read/write, youngest wins
      drive(1'b1, 1'b0, 32'h40, 32'hDEAD); cycle();
      drive(1'b0, 1'b1, 32'h40, 32'h0);
      expect_v(OBS_RDATA, 32'hDEAD, "fwd_dead");
      expect_v(OBS_COUNT, 32'd1,    "fwd_count1");
      cycle();
      drive(1'b1, 1'b1, 32'h40, 32'hBEEF);
      expect_v(OBS_RDATA, 32'hDEAD, "same_addr_prewrite");
      cycle();
      drive(1'b0, 1'b1, 32'h40, 32'h0);
      expect_v(OBS_RDATA, 32'hBEEF, "fwd_youngest");
      expect_v(OBS_COUNT, 32'd2,    "fwd_count2");
      cycle();
      drive(1'b0, 1'b0, 32'h0, 32'h0); cycle(); cycle();
      drive(1'b0, 1'b1, 32'h40, 32'h0);
      expect_v(OBS_RDATA, 32'hBEEF, "arr_beef");
      expect_v(OBS_COUNT, 32'd0,    "fwd_drained");
      cycle();

      // ---------------- overflow: preload 0x110, then 5 write+read cycles
      drive(1'b1, 1'b0, 32'h110, 32'h55); cycle();
      drive(1'b0, 1'b0, 32'h0, 32'h0);    cycle();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
         expect_v(OBS_COUNT, 32'(i), "ovf_fill_count");
         cycle();
      end
      drive(1'b0, 1'b1, 32'h110, 32'h0);
      expect_v(OBS_COUNT, 32'd4,  "ovf_count");
      expect_v(OBS_EOVF,  32'd1,  "ovf_flag");
      expect_v(OBS_RDATA, 32'h55, "ovf_no_fwd");
      cycle();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) cycle();
      drive(1'b0, 1'b1, 32'h110, 32'h0);
      expect_v(OBS_RDATA, 32'h55, "ovf_dropped");
      expect_v(OBS_COUNT, 32'd0,  "ovf_drained");
      cycle();
      drive(1'b0, 1'b1, 32'h10C, 32'h0); expect_v(OBS_RDATA, 32'hA3, "ovf_kept3"); cycle();
      drive(1'b0, 1'b1, 32'h100, 32'h0); expect_v(OBS_RDATA, 32'hA0, "ovf_kept0"); cycle();

      // ---------------- HALT register
      drive(1'b1, 1'b0, HALT_A, 32'h5);
      expect_v(OBS_HVALID, 32'd0, "halt_pre");
      cycle();
      drive(1'b1, 1'b0, HALT_A, 32'h9);
      expect_v(OBS_HVALID, 32'd1, "halt_valid");
      expect_v(OBS_HCODE,  32'h5, "halt_code1");
      cycle();
      drive(1'b0, 1'b1, HALT_A, 32'h0);
      expect_v(OBS_RDATA, 32'd0, "halt_read0");
      expect_v(OBS_HCODE, 32'h5, "halt_code_hold");
      expect_v(OBS_COUNT, 32'd0, "halt_no_enqueue");
      cycle();

      // ---------------- unmapped access
      drive(1'b0, 1'b1, 32'h0001_0000, 32'h0);
      expect_v(OBS_RDATA,  32'd0, "unmapped_rdata");
      expect_v(OBS_ERANGE, 32'd0, "erange_pre");
      cycle();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      expect_v(OBS_ERANGE, 32'd1, "erange_set");
      cycle();

      // ---------------- reset mid-stream with three pending writes
      drive(1'b1, 1'b0, 32'h200, 32'h70); cycle();
      drive(1'b1, 1'b0, 32'h204, 32'h71); cycle();
      drive(1'b1, 1'b0, 32'h208, 32'h72); cycle();
      drive(1'b0, 1'b0, 32'h0, 32'h0);    cycle();
      drive(1'b1, 1'b1, 32'h200, 32'hC0); cycle();
      drive(1'b1, 1'b1, 32'h204, 32'hC1); cycle();
      drive(1'b1, 1'b1, 32'h208, 32'hC2); cycle();
      drive(1'b0, 1'b1, 32'h200, 32'h0);
      expect_v(OBS_COUNT, 32'd3,  "pend_count");
      expect_v(OBS_RDATA, 32'hC0, "pend_fwd");
      cycle();
      rst = 1'b0;
      expect_v(OBS_COUNT,  32'd0, "rst2_count");
      expect_v(OBS_RDATA,  32'd0, "rst2_rdata");
      expect_v(OBS_HVALID, 32'd0, "rst2_hvalid");
      expect_v(OBS_HCODE,  32'd0, "rst2_hcode");
      expect_v(OBS_ERANGE, 32'd0, "rst2_erange");
      expect_v(OBS_EOVF,   32'd0, "rst2_eovf");
      cycle();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      cycle();
      rst = 1'b1;
      cycle(); cycle();
      drive(1'b0, 1'b1, 32'h200, 32'h0); expect_v(OBS_RDATA, 32'h70, "discard0"); cycle();
      drive(1'b0, 1'b1, 32'h204, 32'h0); expect_v(OBS_RDATA, 32'h71, "discard1"); cycle();
      drive(1'b0, 1'b1, 32'h208, 32'h0); expect_v(OBS_RDATA, 32'h72, "discard2"); cycle();
      drive(1'b0, 1'b0, 32'h0, 32'h0);

      // Let the monitor empty the queue, bounded.
      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      while (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL %s: got no sample, expected 0x%08h", mon_e.name, mon_e.exp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_beta_dmem

// File: doc/beta_dmem.md
Name: beta_dmem

Overview:
- Data-memory responder for the Beta core's data port. It is the target end of the d_mem_* interface that the core drives.
- Contains a word-addressed storage array, a posted write buffer with read forwarding, and a small MMIO window: a free-running cycle counter and a halt/result register that benches poll for end-of-test.
- Sits beside the core in the top level and replaces the behavioural data memory in simulation.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the array; power of two.
- WB_DEPTH, 4, write-buffer entries; power of two, minimum 2.
- MMIO_BASE, 32'hFFFF_FF00, byte address at which the MMIO window starts; window is 256 bytes.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- d_mem_w_addr  in  32  byte address, shared by reads and writes; bits [1:0] ignored
- d_mem_w_data  in  32  write data
- d_mem_we  in  1  write strobe, sampled at posedge clk
- d_mem_oe  in  1  read enable
- d_mem_r_data  out  32  read data, combinational from address in the same cycle
- halt_valid  out  1  set by a write to the HALT register
- halt_code  out  32  data of the first HALT write
- err_range  out  1  sticky; access to an unmapped address
- err_overflow  out  1  sticky; enqueue while full with no drain
- wb_count  out  $clog2(WB_DEPTH)+1  current write-buffer occupancy

Behaviour:
- Reset (rst=0, asynchronous):
  - Write buffer empty, cycle counter 0, halt_valid 0, halt_code 0, both error flags 0.
  - d_mem_r_data is 0 while rst=0.
  - Array contents are not reset.
  - Reset asserted mid-drain discards all pending buffer entries.
- Address decode, word index = addr[31:2]:
  - Array hit when index < MEM_WORDS.
  - MMIO hit when addr >= MMIO_BASE. Offset 0x00 = CYCLE (read-only); offset 0x04 = HALT (write-only, reads return 0).
  - Any other address is unmapped.
- Array writes:
  - A write (d_mem_we=1) to the array enqueues {index, data} at the buffer tail at posedge.
  - Zero write latency seen by the core.
- Drain:
  - In any cycle with d_mem_oe=0 and buffer non-empty, the head entry is written to the array at posedge and popped.
  - Enqueue and drain in the same cycle are both performed; occupancy is unchanged.
- Reads:
  - d_mem_oe=1 to the array returns the youngest buffer entry with a matching index, otherwise the array word.
  - Combinational, zero-cycle latency.
  - A read to an MMIO or unmapped address returns the value defined there (CYCLE, 0, or 0 respectively).
- Simultaneous d_mem_we and d_mem_oe on the same address: the read returns the pre-write value and the write is enqueued. No drain occurs that cycle.
- Overflow:
  - Condition: enqueue while full and no drain that cycle.
  - The new write is dropped and err_overflow is set.
  - This occurs only if the core drives we and oe together.
- CYCLE: increments by 1 every clock after reset release; wraps at 2^32-1 to 0.
- HALT:
  - The first write sets halt_valid=1 and halt_code=data.
  - Later HALT writes are ignored.
  - Both outputs hold until reset.
- Unmapped access (we or oe): err_range set; writes ignored; read returns 0.
- MMIO writes bypass the buffer and take effect at the posedge of the write cycle.
- Buffer pointers wrap modulo WB_DEPTH. Forwarding compares every valid entry; on multiple matches the youngest entry wins.

Decomposition:
- Package beta_dmem_pkg holds:
  - MMIO offset constants CYCLE_OFS and HALT_OFS;
  - typedef wb_entry_t {logic [29:0] idx; logic [31:0] data;};
  - an addr_region_t enum {REG_MEM, REG_MMIO, REG_UNMAPPED}.
- One sub-module, beta_wbuf: the circular FIFO with full/empty/count and a parallel youngest-match lookup port.
- beta_dmem keeps decode, the array, MMIO and the error flags.

Test Plan:
- Reset, then 3 writes to words 0/1/2 (0x11, 0x22, 0x33) with oe=0 between them -> wb_count stays ≤1; after idle the array holds 0x11/0x22/0x33 and wb_count=0.
- Write 0xDEAD to byte addr 0x40, then oe read of 0x40 the next cycle with no drain yet -> r_data=0xDEAD via forwarding. Write 0xBEEF to 0x40, read again -> 0xBEEF (youngest wins).
- Hold we=1, oe=1 for WB_DEPTH+1 cycles to distinct array addresses -> wb_count=4, err_overflow=1, fifth data absent after the drain.
- Release reset, read MMIO_BASE+0 after 10 cycles -> 10 (±1 for sampling edge). Preload the counter to 0xFFFF_FFFF by force, step one cycle -> 0.
- Write 0x5 then 0x9 to MMIO_BASE+4 -> halt_valid=1, halt_code=0x5; reading HALT returns 0.
- Read byte addr 0x0001_0000 -> r_data=0, err_range=1. Assert rst=0 mid-stream with wb_count=3 -> all outputs 0, wb_count=0, and the pending writes never reach the array.
